bus_mem_responder: RTL and testbench

//  Memory-side end of the CPU/FETCH bus: a word-addressed on-chip RAM that answers
//  bus requests (read/write) with a single-cycle S_ACK pulse after a fixed wait count.

---
 rtl/bus_mem_responder_pkg.sv | 30 +++
 rtl/bus_ram_array.sv | 28 ++
 rtl/bus_mem_responder.sv | 104 ++++++++++
 tb/tb_bus_mem_responder.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/bus_mem_responder_pkg.sv
// Shared types for the memory-side bus responder: FSM state codes, bus width, request latch.
// Pure declarations; no latency or backpressure of its own.
// Used by the responder and by bus masters that need the same state encoding.
package bus_mem_responder_pkg;

    localparam int BUS_W = 32;
    localparam logic [BUS_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        BUS_IDLE   = 2'd0,
        BUS_WAIT   = 2'd1,
        BUS_ACCESS = 2'd2,
        BUS_ACK    = 2'd3
    } bus_state_t;

    typedef struct packed {
        logic             write;
        logic             hit;
        logic [BUS_W-1:0] addr;
        logic [BUS_W-1:0] data;
    } bus_req_t;

    // Window decode: everything above the RAM index bits must match the base.
    function automatic logic in_window(input logic [BUS_W-1:0] addr,
                                       input logic [BUS_W-1:0] base,
                                       input int               aw);
        return (addr >> aw) == (base >> aw);
    endfunction

endpackage

// File: rtl/bus_ram_array.sv
// Single-port synchronous RAM, 2**AW x DW, no reset on contents.
// Latency: read data registered, valid the cycle after an enabled read.
// Backpressure: none; every enabled cycle performs the access.
module bus_ram_array #(
    parameter int AW = 10,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          en,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Word-addressed RAM slave on the system bus; out-of-window accesses ack with sticky S_ERR.
// Latency: S_ACK pulses the cycle after edge t+2+WAIT_CYCLES (request sampled at edge t).
// Backpressure: one transaction at a time; master holds request until S_ACK, inputs ignored while busy.
module bus_mem_responder
    import bus_mem_responder_pkg::*;
#(
    parameter int          AW          = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEFAULT
) (
    input  logic        clk,
    input  logic        W_RST,
    input  logic        S_REQ,
    input  logic        S_WRITE,
    input  logic [31:0] S_ADDR,
    input  logic [31:0] S_DATA_I,
    output logic [31:0] S_DATA_O,
    output logic        S_ACK,
    output logic        S_ERR,
    output logic        S_BUSY
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    bus_state_t  state;
    bus_req_t    req_q;
    logic [3:0]  wait_cnt;
    logic [31:0] ram_rdata;
    logic        ram_en;
    logic        ram_we;

    // Gating with reset keeps an aborted write from landing on the reset edge.
    assign ram_en = (state == BUS_ACCESS) && req_q.hit && !W_RST;
    assign ram_we = ram_en && req_q.write;

    bus_ram_array #(
        .AW (AW),
        .DW (BUS_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (req_q.addr[AW-1:0]),
        .wdata (req_q.data),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (W_RST) begin
            state    <= BUS_IDLE;
            S_ACK    <= 1'b0;
            S_DATA_O <= '0;
            S_ERR    <= 1'b0;
            S_BUSY   <= 1'b0;
            wait_cnt <= '0;
        end else begin
            S_ACK    <= 1'b0;
            S_DATA_O <= '0;
            case (state)
                BUS_IDLE: begin
                    if (S_REQ) begin
                        req_q.write <= S_WRITE;
                        req_q.hit   <= in_window(S_ADDR, BASE_ADDR, AW);
                        req_q.addr  <= S_ADDR;
                        req_q.data  <= S_DATA_I;
                        S_BUSY      <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state    <= BUS_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end else begin
                            state <= BUS_ACCESS;
                        end
                    end
                end
                BUS_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state <= BUS_ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                BUS_ACCESS: begin
                    if (!req_q.hit) begin
                        S_ERR <= 1'b1;
                    end
                    state <= BUS_ACK;
                end
                BUS_ACK: begin
                    // RAM read data from the ACCESS edge is valid here; the pulse is registered.
                    S_ACK    <= 1'b1;
                    S_DATA_O <= req_q.write ? '0 : (req_q.hit ? ram_rdata : ERR_DATA);
                    S_BUSY   <= 1'b0;
                    state    <= BUS_IDLE;
                end
                default: begin
                    state  <= BUS_IDLE;
                    S_BUSY <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
// Directed bench for bus_mem_responder: scoreboarded read data, latency, reset abort, window errors.
module tb_bus_mem_responder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req, wr;
    logic [31:0] addr, wdat;
    logic [31:0] rdat;
    logic        ack, err, busy;

    logic        req2, wr2;
    logic [31:0] addr2, wdat2;
    logic [31:0] rdat0, rdat3;
    logic        ack0, ack3, err0, err3, busy0, busy3;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sbq[$];
    logic [31:0] mexp;
    bit          mon_en = 1'b0;
    logic        prev_ack = 1'b0;

    bus_mem_responder #(.WAIT_CYCLES(1)) dut (
        .clk(clk), .W_RST(rst), .S_REQ(req), .S_WRITE(wr), .S_ADDR(addr),
        .S_DATA_I(wdat), .S_DATA_O(rdat), .S_ACK(ack), .S_ERR(err), .S_BUSY(busy)
    );

    bus_mem_responder #(.WAIT_CYCLES(0)) dut_w0 (
        .clk(clk), .W_RST(rst), .S_REQ(req2), .S_WRITE(wr2), .S_ADDR(addr2),
        .S_DATA_I(wdat2), .S_DATA_O(rdat0), .S_ACK(ack0), .S_ERR(err0), .S_BUSY(busy0)
    );

    bus_mem_responder #(.WAIT_CYCLES(3)) dut_w3 (
        .clk(clk), .W_RST(rst), .S_REQ(req2), .S_WRITE(wr2), .S_ADDR(addr2),
        .S_DATA_I(wdat2), .S_DATA_O(rdat3), .S_ACK(ack3), .S_ERR(err3), .S_BUSY(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Every ACK pops one scoreboard entry; outside ACK the data bus must be zero.
    always @(negedge clk) begin
        if (mon_en) begin
            if (ack) begin
                chk("ack_expected", 32'(sbq.size() > 0), 32'd1);
                if (sbq.size() > 0) begin
                    mexp = sbq.pop_front();
                    chk("ack_data", rdat, mexp);
                end
                chk("ack_width", 32'(prev_ack), 32'd0);
            end else begin
                chk("idle_data_zero", rdat, 32'd0);
            end
        end
        prev_ack <= ack;
    end

    task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] expd, input bit hold, input string tag);
        int n;
        sbq.push_back(expd);
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; wdat = d;
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
        n = 0;
        while (n < 20) begin
            @(posedge clk);
            n++;
            #1;
            if (ack) break;
        end
        chk({tag, "_latency"}, 32'(n), 32'd3);
    endtask

    task automatic meas(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] expd, input string tag);
        int l0, l3, c0, c3;
        logic [31:0] d0, d3;
        l0 = -1; l3 = -1; c0 = 0; c3 = 0; d0 = 'x; d3 = 'x;
        @(negedge clk);
        req2 = 1'b1; wr2 = w; addr2 = a; wdat2 = d;
        @(posedge clk);
        #1;
        req2 = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk);
            #1;
            if (ack0) begin
                c0++;
                if (l0 < 0) begin l0 = n; d0 = rdat0; end
            end
            if (ack3) begin
                c3++;
                if (l3 < 0) begin l3 = n; d3 = rdat3; end
            end
        end
        chk({tag, "_lat_w0"}, 32'(l0), 32'd2);
        chk({tag, "_lat_w3"}, 32'(l3), 32'd5);
        chk({tag, "_width_w0"}, 32'(c0), 32'd1);
        chk({tag, "_width_w3"}, 32'(c3), 32'd1);
        chk({tag, "_data_w0"}, d0, expd);
        chk({tag, "_data_w3"}, d3, expd);
    endtask

    initial begin
        rst = 1'b1; req = 1'b1; wr = 1'b0; addr = 32'h5; wdat = 32'h0;
        req2 = 1'b0; wr2 = 1'b0; addr2 = 32'h0; wdat2 = 32'h0;

        // Reset held with a pending request: nothing may start.
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_ack", 32'(ack), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_err", 32'(err), 32'd0);
            chk("rst_data", rdat, 32'd0);
        end
        @(negedge clk);
        rst = 1'b0; req = 1'b0;
        mon_en = 1'b1;
        repeat (3) @(posedge clk);

        // Write then read back with one wait state.
        txn(1'b1, 32'h5, 32'h12345678, 32'h0, 1'b0, "wr5");
        txn(1'b0, 32'h5, 32'h0, 32'h12345678, 1'b0, "rd5");

        // Zero and three wait states.
        meas(1'b1, 32'h3, 32'hCAFE0003, 32'h0, "w3");
        meas(1'b0, 32'h3, 32'h0, 32'hCAFE0003, "r3");

        // Out-of-window accesses.
        txn(1'b0, 32'h400, 32'h0, 32'hDEADBEEF, 1'b0, "rd_oow");
        @(posedge clk); #1;
        chk("err_set", 32'(err), 32'd1);
        txn(1'b1, 32'h405, 32'h99, 32'h0, 1'b0, "wr_oow");
        txn(1'b0, 32'h5, 32'h0, 32'h12345678, 1'b0, "rd5_after_oow");
        chk("err_sticky", 32'(err), 32'd1);

        // Back-to-back reads with S_REQ held high throughout.
        for (int i = 0; i < 4; i++) txn(1'b1, 32'(i), 32'h10000000 + 32'(i), 32'h0, 1'b0, "fill");
        for (int i = 0; i < 4; i++) txn(1'b0, 32'(i), 32'h0, 32'h10000000 + 32'(i), (i < 3), "b2b");

        // Reset during WAIT of a write aborts it without touching RAM.
        txn(1'b1, 32'h7, 32'hAAAA0000, 32'h0, 1'b0, "wr7");
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 32'h7; wdat = 32'h55555555;
        @(posedge clk);
        #1;
        req = 1'b0; rst = 1'b1;
        chk("busy_in_wait", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_err_cleared", 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        txn(1'b0, 32'h7, 32'h0, 32'hAAAA0000, 1'b0, "rd7_after_abort");

        repeat (2) @(posedge clk);
        #1;
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        chk("w0_err", 32'(err0), 32'd0);
        chk("w3_err", 32'(err3), 32'd0);
        chk("w0_busy", 32'(busy0), 32'd0);
        chk("w3_busy", 32'(busy3), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
